// File: rtl/cpu_alu_mc.sv
// cpu_alu_mc: single-issue ALU with a valid/ready handshake on both sides.
// Most operations complete in one cycle. MULL/MULH run a bit-serial
// shift-add multiplier for WIDTH cycles before presenting a result.
module cpu_alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             OF,
    output logic             OF_en,
    output logic             CF,
    output logic             CF_en,
    output logic             ZF,
    output logic             ZF_en,
    output logic             NF,
    output logic             NF_en,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mplier;
    logic [SHW-1:0]       r_cnt;
    logic                 r_mulHigh;

    logic                 w_accept;
    logic                 w_isMul;
    logic [SHW-1:0]       w_sh;
    logic [SHW-1:0]       w_negSh;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_res;
    logic                 w_err;
    logic                 w_of;
    logic                 w_cf;
    logic                 w_arithEn;
    logic                 w_znEn;
    logic [2*WIDTH-1:0]   w_prodNext;
    logic [WIDTH-1:0]     w_mulRes;

    // Handshake and status decode straight from the state register
    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        w_accept  = in_valid && in_ready;
        w_isMul   = (op == 4'd2) || (op == 4'd3);
        out_valid = (r_state == DONE);
        busy      = (r_state == MUL);
    end

    // Single-cycle datapath; rotates use the negated amount so a zero amount folds back to a
    always_comb begin
        w_sh      = b[SHW-1:0];
        w_negSh   = -w_sh;
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = a - b;
        w_res     = '0;
        w_err     = 1'b0;
        w_of      = 1'b0;
        w_cf      = 1'b0;
        w_arithEn = 1'b0;
        w_znEn    = 1'b1;
        case (op)
            4'd0: begin
                w_res     = w_sum[WIDTH-1:0];
                w_cf      = w_sum[WIDTH];
                w_of      = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
                w_arithEn = 1'b1;
            end
            4'd1: begin
                w_res     = w_diff;
                w_cf      = (a < b);
                w_of      = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
                w_arithEn = 1'b1;
            end
            4'd2, 4'd3: w_res = '0;
            4'd4: w_res = a << w_sh;
            4'd5: w_res = a >> w_sh;
            4'd6: w_res = $signed(a) >>> w_sh;
            4'd7: w_res = (a >> w_sh) | (a << w_negSh);
            4'd8: w_res = (a << w_sh) | (a >> w_negSh);
            4'd9: begin
                w_res  = b;
                w_znEn = 1'b0;
            end
            4'd10: w_res = a;
            default: begin
                w_err  = 1'b1;
                w_znEn = 1'b0;
            end
        endcase
    end

    // One shift-add step; the final step's sum is used directly so the result lands on the last MUL edge
    always_comb begin
        w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);
        w_mulRes   = r_mulHigh ? w_prodNext[2*WIDTH-1:WIDTH] : w_prodNext[WIDTH-1:0];
    end

    // Control FSM with registered result and flag outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_mulHigh <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            OF        <= 1'b0;
            OF_en     <= 1'b0;
            CF        <= 1'b0;
            CF_en     <= 1'b0;
            ZF        <= 1'b0;
            ZF_en     <= 1'b0;
            NF        <= 1'b0;
            NF_en     <= 1'b0;
        end else if (w_accept) begin
            if (w_isMul) begin
                r_state   <= MUL;
                r_mcand   <= {{WIDTH{1'b0}}, a};
                r_mplier  <= b;
                r_prod    <= '0;
                r_cnt     <= '0;
                r_mulHigh <= op[0];
            end else begin
                r_state <= DONE;
                result  <= w_res;
                err     <= w_err;
                OF      <= w_of;
                OF_en   <= w_arithEn;
                CF      <= w_cf;
                CF_en   <= w_arithEn;
                ZF      <= w_znEn && (w_res == '0);
                ZF_en   <= w_znEn;
                NF      <= w_znEn && w_res[MSB];
                NF_en   <= w_znEn;
            end
        end else begin
            case (r_state)
                MUL: begin
                    r_prod   <= w_prodNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= DONE;
                        result  <= w_mulRes;
                        err     <= 1'b0;
                        OF      <= 1'b0;
                        OF_en   <= 1'b0;
                        CF      <= 1'b0;
                        CF_en   <= 1'b0;
                        ZF      <= (w_mulRes == '0);
                        ZF_en   <= 1'b1;
                        NF      <= w_mulRes[MSB];
                        NF_en   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
